// File: rtl/ppu_dma_pkg.sv
// Shared types and constants for the multi-channel sprite DMA.
// Holds the FSM encoding, the default register map and the channel-index width helper.
package ppu_dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_ALIGN,
        ST_RD,
        ST_WR,
        ST_DONE
    } dma_state_t;

    localparam logic [15:0] TRIG_ADDR_CH0    = 16'h4014;
    localparam logic [15:0] TRIG_ADDR_CH1    = 16'h4018;
    localparam logic [15:0] DST_ADDR_OAMDATA = 16'h2004;

    // A single channel still needs one index bit so vectors never collapse to zero width.
    function automatic int ch_idx_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/ppu_dma_arb.sv
// Fixed-priority arbiter over the pending-channel vector; the lowest index wins.
// Purely combinational: one-hot grant, encoded index and an any-pending flag.
module ppu_dma_arb
    import ppu_dma_pkg::*;
#(
    parameter int NCH = 2
) (
    input  logic [NCH-1:0]              pend,
    output logic [NCH-1:0]              gnt_oh,
    output logic [ch_idx_w(NCH)-1:0]    gnt_idx,
    output logic                        any_pend
);

    localparam int CW = ch_idx_w(NCH);

    always_comb begin
        gnt_oh   = '0;
        gnt_idx  = '0;
        any_pend = |pend;
        // Scan from the top down so the last hit, the lowest index, is the one that sticks.
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pend[k]) begin
                gnt_oh    = '0;
                gnt_oh[k] = 1'b1;
                gnt_idx   = CW'(k);
            end
        end
    end

endmodule

// File: rtl/ppu_dma_mc.sv
// Multi-channel sprite DMA: snoops trigger writes, arbitrates channels and copies
// LEN bytes from page {page,8'h00} to the channel's destination over the req/gnt master port.
module ppu_dma_mc
    import ppu_dma_pkg::*;
#(
    parameter int              NCH        = 2,
    parameter int              LEN        = 256,
    parameter logic [NCH*16-1:0] TRIG_ADDRS = {TRIG_ADDR_CH1, TRIG_ADDR_CH0},
    parameter logic [NCH*16-1:0] DST_ADDRS  = {DST_ADDR_OAMDATA, DST_ADDR_OAMDATA},
    parameter bit              ODD_ALIGN  = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [15:0] i_bus_addr,
    input  logic        i_bus_wn,
    input  logic [7:0]  i_bus_wdata,
    output logic        o_spr_req,
    input  logic        i_spr_gnt,
    output logic [15:0] o_spr_addr,
    output logic        o_spr_wn,
    output logic [7:0]  o_spr_wdata,
    input  logic [7:0]  i_spr_rdata,
    output logic        o_busy,
    output logic [1:0]  o_active_ch,
    output logic        o_done
);

    localparam int              IW       = $clog2(LEN);
    localparam int              CW       = ch_idx_w(NCH);
    localparam logic [IW-1:0]   IDX_LAST = IW'(LEN - 1);

    dma_state_t         state_q, state_d;
    logic [NCH-1:0]     pend_q, pend_d, pend_clr, trig;
    logic [NCH-1:0]     cur_oh_q, cur_oh_d;
    logic [7:0]         page_q [NCH];
    logic [7:0]         cur_page_q, cur_page_d;
    logic [15:0]        dst_q, dst_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [7:0]         data_q, data_d;
    logic               parity_q;
    logic               req_q, req_d;
    logic [15:0]        addr_q, addr_d;
    logic               wn_q, wn_d;
    logic               done_q, done_d;
    logic [1:0]         active_ch_q, active_ch_d;

    logic [NCH-1:0]     arb_oh;
    logic [CW-1:0]      arb_idx;
    logic               arb_any;
    logic [7:0]         arb_page, req_page;
    logic [15:0]        arb_dst;

    ppu_dma_arb #(.NCH(NCH)) u_arb (
        .pend     (pend_q),
        .gnt_oh   (arb_oh),
        .gnt_idx  (arb_idx),
        .any_pend (arb_any)
    );

    // A snooped write only counts while the CPU owns the bus, so the DMA's own writes never trigger.
    always_comb begin
        trig = '0;
        for (int k = 0; k < NCH; k++) begin
            trig[k] = !i_bus_wn && !i_spr_gnt && (i_bus_addr == TRIG_ADDRS[16*k +: 16]);
        end
    end

    assign pend_d = (pend_q & ~pend_clr) | trig;

    always_comb begin
        arb_page = '0;
        arb_dst  = '0;
        req_page = '0;
        for (int k = 0; k < NCH; k++) begin
            if (arb_oh[k]) begin
                arb_page = page_q[k];
                arb_dst  = DST_ADDRS[16*k +: 16];
            end
            if (cur_oh_q[k]) begin
                req_page = page_q[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cur_oh_d    = cur_oh_q;
        cur_page_d  = cur_page_q;
        dst_d       = dst_q;
        data_d      = data_q;
        active_ch_d = active_ch_q;
        pend_clr    = '0;
        addr_d      = '0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    cur_oh_d    = arb_oh;
                    active_ch_d = 2'(arb_idx);
                    cur_page_d  = arb_page;
                    dst_d       = arb_dst;
                    idx_d       = '0;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                // Track retriggers until the grant lands; the transfer only starts then.
                cur_page_d = req_page;
                if (i_spr_gnt) begin
                    pend_clr = cur_oh_q;
                    state_d  = (ODD_ALIGN && parity_q) ? ST_ALIGN : ST_RD;
                end
            end
            ST_ALIGN: begin
                if (i_spr_gnt) state_d = ST_RD;
            end
            ST_RD: begin
                if (i_spr_gnt) begin
                    data_d  = i_spr_rdata;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (i_spr_gnt) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + IW'(1);
                        state_d = ST_RD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Master outputs are registered from the next state so they change only on the clock.
        req_d  = state_d inside {ST_REQ, ST_ALIGN, ST_RD, ST_WR};
        wn_d   = (state_d != ST_WR);
        done_d = (state_d == ST_DONE);
        if (state_d == ST_RD) begin
            addr_d = {cur_page_d, 8'(idx_d)};
        end else if (state_d == ST_WR) begin
            addr_d = dst_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= ST_IDLE;
            pend_q      <= '0;
            cur_oh_q    <= '0;
            idx_q       <= '0;
            parity_q    <= 1'b0;
            req_q       <= 1'b0;
            addr_q      <= '0;
            wn_q        <= 1'b1;
            data_q      <= '0;
            done_q      <= 1'b0;
            active_ch_q <= '0;
        end else begin
            state_q     <= state_d;
            pend_q      <= pend_d;
            cur_oh_q    <= cur_oh_d;
            idx_q       <= idx_d;
            parity_q    <= ~parity_q;
            req_q       <= req_d;
            addr_q      <= addr_d;
            wn_q        <= wn_d;
            data_q      <= data_d;
            done_q      <= done_d;
            active_ch_q <= active_ch_d;
        end
    end

    always_ff @(posedge i_clk) begin
        cur_page_q <= cur_page_d;
        dst_q      <= dst_d;
        for (int k = 0; k < NCH; k++) begin
            if (trig[k]) page_q[k] <= i_bus_wdata;
        end
    end

    assign o_spr_req   = req_q;
    assign o_spr_addr  = addr_q;
    // Losing the grant mid-transfer must never leave a write strobe on the bus.
    assign o_spr_wn    = wn_q | ~i_spr_gnt;
    assign o_spr_wdata = data_q;
    assign o_done      = done_q;
    assign o_active_ch = active_ch_q;
    assign o_busy      = (|pend_q) | (state_q inside {ST_REQ, ST_ALIGN, ST_RD, ST_WR});

endmodule

// File: tb/tb_ppu_dma_mc.sv
// Self-checking bench for ppu_dma_mc: transaction-level reference model plus directed scenarios
// and a randomized trigger/grant phase.
module tb_ppu_dma_mc;

    localparam int NCH = 2;
    localparam int LEN = 256;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic [15:0] bus_addr = '0;
    logic        bus_wn = 1'b1;
    logic [7:0]  bus_wdata = '0;
    logic        spr_req;
    logic        spr_gnt = 1'b0;
    logic [15:0] spr_addr;
    logic        spr_wn;
    logic [7:0]  spr_wdata;
    logic [7:0]  spr_rdata;
    logic        busy;
    logic [1:0]  active_ch;
    logic        done;

    always #5 clk = ~clk;

    function automatic logic [7:0] rd_f(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5A;
    endfunction

    function automatic logic [15:0] trig_addr(input int k);
        return (k == 0) ? 16'h4014 : 16'h4018;
    endfunction

    assign spr_rdata = rd_f(spr_addr);

    ppu_dma_mc dut (
        .i_clk       (clk),
        .i_rstn      (rstn),
        .i_bus_addr  (bus_addr),
        .i_bus_wn    (bus_wn),
        .i_bus_wdata (bus_wdata),
        .o_spr_req   (spr_req),
        .i_spr_gnt   (spr_gnt),
        .o_spr_addr  (spr_addr),
        .o_spr_wn    (spr_wn),
        .o_spr_wdata (spr_wdata),
        .i_spr_rdata (spr_rdata),
        .o_busy      (busy),
        .o_active_ch (active_ch),
        .o_done      (done)
    );

    int n_pass = 0;
    int n_total = 0;

    logic        drv_rstn = 1'b0;
    logic [15:0] drv_addr = '0;
    logic        drv_wn = 1'b1;
    logic [7:0]  drv_wdata = '0;
    int          gnt_mode = 0;

    // Model: phase 0 idle, 1 waiting for grant, 2 align slot, 3 copying (step s), 4 done pulse.
    int          m_phase, m_s, m_ch;
    logic [7:0]  m_pg;
    bit          m_par;
    bit          m_pend [NCH];
    logic [7:0]  m_page [NCH];

    int          obs_req, obs_zero, obs_wr, obs_rd, obs_done;
    logic [15:0] first_rd, last_rd;
    int          rd_page_cnt [256];
    logic [1:0]  done_ch [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic m_reset();
        m_phase = 0; m_s = 0; m_ch = 0; m_pg = '0; m_par = 1'b0;
        for (int k = 0; k < NCH; k++) m_pend[k] = 1'b0;
    endtask

    task automatic m_step();
        bit trig [NCH];
        bit found;
        for (int k = 0; k < NCH; k++)
            trig[k] = !bus_wn && !spr_gnt && (bus_addr == trig_addr(k));
        case (m_phase)
            0: begin
                found = 1'b0;
                for (int k = 0; k < NCH; k++) begin
                    if (m_pend[k] && !found) begin m_ch = k; found = 1'b1; end
                end
                if (found) m_phase = 1;
            end
            1: if (spr_gnt) begin
                m_pg = m_page[m_ch];
                m_pend[m_ch] = 1'b0;
                m_phase = m_par ? 2 : 3;
                m_s = 0;
            end
            2: if (spr_gnt) begin m_phase = 3; m_s = 0; end
            3: if (spr_gnt) begin
                if (m_s == 2 * LEN - 1) m_phase = 4;
                else m_s++;
            end
            default: m_phase = 0;
        endcase
        for (int k = 0; k < NCH; k++) begin
            if (trig[k]) begin m_pend[k] = 1'b1; m_page[k] = bus_wdata; end
        end
        m_par = ~m_par;
    endtask

    task automatic clear_obs();
        obs_req = 0; obs_zero = 0; obs_wr = 0; obs_rd = 0; obs_done = 0;
        first_rd = '0; last_rd = '0;
        foreach (rd_page_cnt[i]) rd_page_cnt[i] = 0;
        done_ch.delete();
    endtask

    task automatic cyc();
        bit          e_req, e_wn, e_done, e_busy, wr_step;
        logic [15:0] e_addr;
        @(negedge clk);
        rstn      = drv_rstn;
        bus_addr  = drv_addr;
        bus_wn    = drv_wn;
        bus_wdata = drv_wdata;
        case (gnt_mode)
            0:       spr_gnt = spr_req;
            1:       spr_gnt = 1'b0;
            default: spr_gnt = spr_req && ($urandom_range(0, 3) != 0);
        endcase
        if (!rstn) m_reset();
        #1;
        e_req   = (m_phase >= 1) && (m_phase <= 3);
        wr_step = (m_phase == 3) && m_s[0];
        e_addr  = '0;
        if (m_phase == 3) e_addr = m_s[0] ? 16'h2004 : {m_pg, 8'(m_s / 2)};
        e_wn    = !(wr_step && spr_gnt);
        e_done  = (m_phase == 4);
        e_busy  = e_req;
        for (int k = 0; k < NCH; k++) if (m_pend[k]) e_busy = 1'b1;
        chk("req", spr_req, e_req);
        chk("addr", spr_addr, e_addr);
        chk("wn", spr_wn, e_wn);
        chk("done", done, e_done);
        chk("busy", busy, e_busy);
        chk("active_ch", active_ch, m_ch);
        if (wr_step) chk("wdata", spr_wdata, rd_f({m_pg, 8'((m_s - 1) / 2)}));
        if (spr_req) obs_req++;
        if (spr_req && spr_gnt && spr_addr == 16'h0000) obs_zero++;
        if (!spr_wn) obs_wr++;
        if (spr_req && spr_gnt && spr_wn && spr_addr != 16'h0000) begin
            if (obs_rd == 0) first_rd = spr_addr;
            last_rd = spr_addr;
            obs_rd++;
            rd_page_cnt[spr_addr[15:8]]++;
        end
        if (done) begin obs_done++; done_ch.push_back(active_ch); end
        if (rstn) m_step();
        @(posedge clk);
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        drv_wn = 1'b0; drv_addr = a; drv_wdata = d;
        cyc();
        drv_wn = 1'b1; drv_addr = '0;
    endtask

    task automatic wait_dones(input int target, input int budget);
        int n = 0;
        while (obs_done < target && n < budget) begin cyc(); n++; end
        chk("done_count_reached", obs_done, target);
        cyc();
    endtask

    task automatic wait_addr(input logic [15:0] a, input string name);
        int n = 0;
        bit found = 1'b0;
        while (!found && n < 600) begin
            cyc(); n++;
            #1;
            if (spr_addr == a) found = 1'b1;
        end
        chk(name, found, 1'b1);
    endtask

    task automatic set_parity(input bit want);
        if (m_par != want) cyc();
    endtask

    initial begin
        int n;
        m_reset();
        clear_obs();
        for (int k = 0; k < NCH; k++) m_page[k] = '0;

        // Reset state
        repeat (3) cyc();
        #1;
        chk("rst_req", spr_req, 1'b0);
        chk("rst_addr", spr_addr, 16'h0000);
        chk("rst_wn", spr_wn, 1'b1);
        chk("rst_wdata", spr_wdata, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_ch", active_ch, 2'd0);
        drv_rstn = 1'b1;
        repeat (4) cyc();

        // Single transfer with even grant parity: no align slot
        gnt_mode = 0;
        set_parity(1'b0);
        clear_obs();
        bus_write(16'h4014, 8'h02);
        wait_dones(1, 700);
        chk("single_first_rd", first_rd, 16'h0200);
        chk("single_last_rd", last_rd, 16'h02FF);
        chk("single_reads", obs_rd, 256);
        chk("single_writes", obs_wr, 256);
        chk("single_dones", obs_done, 1);
        chk("single_req_cycles", obs_req, 513);
        chk("single_zero_addr_grants", obs_zero, 1);

        // Odd grant parity: exactly one align slot
        repeat (3) cyc();
        set_parity(1'b1);
        clear_obs();
        bus_write(16'h4014, 8'h02);
        wait_dones(1, 700);
        chk("align_req_cycles", obs_req, 514);
        chk("align_zero_addr_grants", obs_zero, 2);
        chk("align_first_rd", first_rd, 16'h0200);

        // Grant drop for 3 cycles during the read of idx 0x40
        repeat (3) cyc();
        clear_obs();
        bus_write(16'h4014, 8'h02);
        wait_addr(16'h0240, "drop_found_0240");
        gnt_mode = 1;
        n = obs_wr;
        repeat (3) begin
            cyc();
            #1;
            chk("drop_addr_hold", spr_addr, 16'h0240);
        end
        chk("drop_no_writes", obs_wr, n);
        gnt_mode = 0;
        wait_dones(1, 700);
        chk("drop_reads", obs_rd, 256);
        chk("drop_writes", obs_wr, 256);
        chk("drop_last_rd", last_rd, 16'h02FF);

        // Retrigger before the grant: only the second page is copied
        repeat (3) cyc();
        clear_obs();
        gnt_mode = 1;
        bus_write(16'h4014, 8'h07);
        repeat (3) cyc();
        bus_write(16'h4014, 8'h08);
        repeat (2) cyc();
        gnt_mode = 0;
        wait_dones(1, 700);
        #1;
        chk("retrig_busy_after", busy, 1'b0);
        chk("retrig_page07", rd_page_cnt[8'h07], 0);
        chk("retrig_page08", rd_page_cnt[8'h08], 256);

        // Two channels pending together: lowest index served first
        repeat (3) cyc();
        clear_obs();
        bus_write(16'h4014, 8'h01);
        n = 0;
        while (obs_rd < 10 && n < 100) begin cyc(); n++; end
        gnt_mode = 1;
        bus_write(16'h4018, 8'h03);
        bus_write(16'h4014, 8'h05);
        gnt_mode = 0;
        wait_dones(3, 2500);
        chk("two_done_count", done_ch.size(), 3);
        chk("two_done_ch1st", (done_ch.size() > 1) ? done_ch[1] : 2'd3, 2'd0);
        chk("two_done_ch2nd", (done_ch.size() > 2) ? done_ch[2] : 2'd3, 2'd1);
        chk("two_page01", rd_page_cnt[8'h01], 256);
        chk("two_page05", rd_page_cnt[8'h05], 256);
        chk("two_page03", rd_page_cnt[8'h03], 256);

        // Asynchronous reset in the middle of a transfer
        repeat (3) cyc();
        bus_write(16'h4014, 8'h02);
        wait_addr(16'h0264, "rstmid_found_0264");
        #1;
        rstn = 1'b0;
        drv_rstn = 1'b0;
        #1;
        chk("rstmid_req_drop", spr_req, 1'b0);
        chk("rstmid_busy_drop", busy, 1'b0);
        repeat (3) cyc();
        drv_rstn = 1'b1;
        repeat (20) begin
            cyc();
            #1;
            chk("rstmid_stay_idle_busy", busy, 1'b0);
            chk("rstmid_stay_idle_req", spr_req, 1'b0);
        end

        // Randomized triggers, stray writes and grant drops against the model
        gnt_mode = 2;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                int sel;
                sel = $urandom_range(0, 3);
                drv_wn    = 1'b0;
                drv_addr  = (sel == 0) ? 16'h4014 : (sel == 1) ? 16'h4018 :
                            (sel == 2) ? 16'h2004 : 16'($urandom);
                drv_wdata = 8'($urandom_range(0, 255));
            end else begin
                drv_wn   = 1'b1;
                drv_addr = '0;
            end
            cyc();
        end
        drv_wn = 1'b1;
        drv_addr = '0;
        gnt_mode = 0;
        n = 0;
        while (busy && n < 3000) begin cyc(); n++; end
        cyc();
        #1;
        chk("drain_idle", busy, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
